// File: rtl/load_store_unit_if.sv
// Request, memory and response signal bundle between execute, the load/store
// unit and the data RAM. The slave modport is the unit's view.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;

   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_err;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata,
      output resp_valid, resp_rdata, resp_rd, resp_err,
      input  resp_ready
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata,
      input  resp_valid, resp_rdata, resp_rd, resp_err,
      output resp_ready
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: checks and aligns one load/store at a time, runs a
// req/ack word access with a timeout, and returns extended load data.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic               clk,
   input  logic               reset,
   load_store_unit_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [29:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [4:0]  resp_rd_q, resp_rd_d;
   logic [1:0]  resp_err_q, resp_err_d;

   logic        f3_legal;
   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] lane;
   logic [31:0] load_ext;
   logic        timeout_hit;

   always_comb begin : decode
      f3_legal   = 1'b0;
      misaligned = 1'b0;
      be_new     = 4'b1111;
      wdata_new  = bus.req_wdata;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = !bus.req_we;
         default:                f3_legal = 1'b0;
      endcase
      case (bus.req_funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << bus.req_addr[1:0];
            wdata_new = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = bus.req_addr[0];
            be_new     = 4'b0011 << {bus.req_addr[1], 1'b0};
            wdata_new  = {2{bus.req_wdata[15:0]}};
         end
         default: misaligned = (bus.req_addr[1:0] != 2'b00);
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend per funct3.
   always_comb begin : extract
      lane     = bus.mem_rdata >> {off_q, 3'b000};
      load_ext = lane;
      case (funct3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end else begin : g_timeout
         assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
      end
   endgenerate

   always_comb begin : next_state
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_rd_d    = resp_rd_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d         = bus.req_we;
               funct3_d     = bus.req_funct3;
               off_d        = bus.req_addr[1:0];
               cnt_d        = '0;
               resp_rdata_d = 32'd0;
               resp_rd_d    = bus.req_we ? 5'd0 : bus.req_rd;
               if (!f3_legal) begin
                  resp_err_d = 2'b11;
                  state_d    = DONE;
               end else if (misaligned) begin
                  resp_err_d = 2'b01;
                  state_d    = DONE;
               end else begin
                  resp_err_d  = 2'b00;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = bus.req_addr[31:2];
                  mem_be_d    = be_new;
                  mem_wdata_d = wdata_new;
                  state_d     = ACCESS;
               end
            end
         end
         ACCESS: begin
            // An ack in the timeout cycle still completes the access normally.
            if (bus.mem_ack) begin
               resp_rdata_d = we_q ? 32'd0 : load_ext;
               resp_err_d   = 2'b00;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               state_d      = DONE;
            end else if (timeout_hit) begin
               resp_err_d = 2'b10;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.resp_ready) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 30'd0;
         mem_be_q     <= 4'd0;
         mem_wdata_q  <= 32'd0;
         resp_rdata_q <= 32'd0;
         resp_rd_q    <= 5'd0;
         resp_err_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_rd_q    <= resp_rd_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == DONE);
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_rd    = resp_rd_q;
   assign bus.resp_err   = resp_err_q;

endmodule
